core_sequencer: RTL and testbench

Multi-cycle control FSM for the RV32I core. It sits between the instruction fetch port, the instruction decoder, the ALU and the data-memory port. It takes the decoder's per-instruction enable flags and turns them into timed strobes: fetch, IR load, ALU start, memory request, register write-back and PC update. It also guards the fetch and memory handshakes with a timeout, raises sticky traps, and counts retired instructions.

---
 rtl/core_pkg.sv | 41 ++++
 rtl/seq_wait_timer.sv | 39 +++
 rtl/core_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_core_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the RV32I multi-cycle sequencer:
//   seq_state_t  - FSM state encoding (also exported on the debug 'state' port)
//   trap_cause_t - sticky trap cause codes
//   PC_SEL_*     - encoding of the pc_sel mux select
//   take_target  - decides whether the PC update uses the jump/branch target
// ----------------------------------------------------------------------------
package core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_TRAP   = 3'd7
    } seq_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_INVALID = 2'b01,
        CAUSE_IF_TMO  = 2'b10,
        CAUSE_MEM_TMO = 2'b11
    } trap_cause_t;

    localparam logic PC_SEL_SEQ = 1'b0;  // PC + 4
    localparam logic PC_SEL_TGT = 1'b1;  // jump / branch target

    // Jumps always redirect; branches only when the compare latched in EXEC
    // came out taken.
    function automatic logic take_target(input logic is_jal,
                                         input logic is_jalr,
                                         input logic is_branch,
                                         input logic br_q);
        return is_jal | is_jalr | (is_branch & br_q);
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// ----------------------------------------------------------------------------
// seq_wait_timer
// Handshake watchdog shared by the fetch and data-memory request phases.
//   clk, nreset : clock, asynchronous active-low reset
//   clr         : restart the count (asserted on entry to a request phase)
//   run         : a request is being held this cycle
//   ack         : the request is acknowledged this cycle
//   expired     : combinational; last allowed request cycle passed with no ack
// The request may be held for exactly TIMEOUT cycles; an ack in the last of
// them still wins, because expiry is qualified with !ack.
// ----------------------------------------------------------------------------
module seq_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic nreset,
    input  logic clr,
    input  logic run,
    input  logic ack,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run && !ack) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = run && !ack && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/core_sequencer.sv
// ----------------------------------------------------------------------------
// core_sequencer
// Multi-cycle control FSM for the RV32I core. Turns the decoder's enable flags
// into timed strobes and guards the fetch / memory handshakes with a timeout.
//   clk, nreset          : clock, asynchronous active-low reset
//   halt_req             : stop request, honoured at instruction boundaries
//   if_req / if_ack      : instruction fetch handshake
//   ir_load              : latch fetched word into IR (same cycle as if_ack)
//   dec_*                : decoder flags, stable from DECODE onward
//   br_taken             : ALU compare result, sampled in EXEC
//   alu_go               : ALU evaluate strobe
//   mem_req/mem_we/ack   : data-memory handshake (mem_we 1 = store)
//   reg_we               : register write-back of bus C into rd
//   pc_load / pc_sel     : PC update strobe and source select
//   trap / trap_cause    : sticky trap flag and cause (registered)
//   instret              : retired-instruction counter, wraps
//   state                : current FSM state for debug
// All strobes decode from the state register (plus a few decoder/ack terms),
// so an asynchronous reset drops any in-flight request immediately.
// ----------------------------------------------------------------------------
module core_sequencer
    import core_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             halt_req,
    output logic             if_req,
    input  logic             if_ack,
    output logic             ir_load,
    input  logic             dec_rd_enc,
    input  logic             dec_alu_en,
    input  logic             dec_mem_en,
    input  logic             dec_rw,
    input  logic             dec_is_jal,
    input  logic             dec_is_jalr,
    input  logic             dec_is_branch,
    input  logic             dec_is_fence,
    input  logic             dec_is_system,
    input  logic             dec_is_invalid,
    input  logic             br_taken,
    output logic             alu_go,
    output logic             mem_req,
    output logic             mem_we,
    input  logic             mem_ack,
    output logic             reg_we,
    output logic             pc_load,
    output logic             pc_sel,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state
);

    seq_state_t       state_q, state_d;
    trap_cause_t      cause_q, cause_d;
    logic             trap_q, trap_set;
    logic             br_q, latch_br;
    logic             retire;
    logic [CNT_W-1:0] instret_q;

    logic tmr_clr, tmr_run, tmr_ack, tmr_expired;

    // FENCE and SYSTEM take the ordinary EXEC -> WB path; their own flags
    // carry no sequencing information here.
    logic unused_dec;
    assign unused_dec = dec_is_fence ^ dec_is_system;

    // ------------------------------------------------------------------
    // Shared request watchdog. Cleared on the edge that enters FETCH or
    // MEM so each request phase starts from zero.
    // ------------------------------------------------------------------
    assign tmr_run = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign tmr_ack = (state_q == ST_FETCH) ? if_ack : mem_ack;
    assign tmr_clr = (state_d != state_q) &&
                     ((state_d == ST_FETCH) || (state_d == ST_MEM));

    seq_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .nreset  (nreset),
        .clr     (tmr_clr),
        .run     (tmr_run),
        .ack     (tmr_ack),
        .expired (tmr_expired)
    );

    // ------------------------------------------------------------------
    // State and bookkeeping registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= ST_IDLE;
            trap_q    <= 1'b0;
            cause_q   <= CAUSE_NONE;
            br_q      <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (trap_set) begin
                trap_q  <= 1'b1;
                cause_q <= cause_d;
            end
            if (latch_br) begin
                br_q <= br_taken;
            end
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and strobes. Timeout / invalid-opcode checks come before
    // any halt handling; halt_req is only looked at in IDLE, WB and HALT.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cause_d  = CAUSE_NONE;
        trap_set = 1'b0;
        latch_br = 1'b0;
        retire   = 1'b0;
        if_req   = 1'b0;
        ir_load  = 1'b0;
        alu_go   = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        reg_we   = 1'b0;
        pc_load  = 1'b0;
        pc_sel   = PC_SEL_SEQ;

        case (state_q)
            ST_IDLE: begin
                state_d = halt_req ? ST_HALT : ST_FETCH;
            end

            ST_FETCH: begin
                if_req = 1'b1;
                if (if_ack) begin
                    ir_load = 1'b1;
                    state_d = ST_DECODE;
                end else if (tmr_expired) begin
                    state_d  = ST_TRAP;
                    trap_set = 1'b1;
                    cause_d  = CAUSE_IF_TMO;
                end
            end

            ST_DECODE: begin
                if (dec_is_invalid) begin
                    state_d  = ST_TRAP;
                    trap_set = 1'b1;
                    cause_d  = CAUSE_INVALID;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                alu_go   = dec_alu_en;
                latch_br = 1'b1;
                state_d  = dec_mem_en ? ST_MEM : ST_WB;
            end

            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = !dec_rw;
                if (mem_ack) begin
                    state_d = ST_WB;
                end else if (tmr_expired) begin
                    state_d  = ST_TRAP;
                    trap_set = 1'b1;
                    cause_d  = CAUSE_MEM_TMO;
                end
            end

            ST_WB: begin
                reg_we  = dec_rd_enc;
                pc_load = 1'b1;
                pc_sel  = take_target(dec_is_jal, dec_is_jalr, dec_is_branch, br_q)
                          ? PC_SEL_TGT : PC_SEL_SEQ;
                retire  = 1'b1;
                state_d = halt_req ? ST_HALT : ST_FETCH;
            end

            ST_HALT: begin
                if (!halt_req) begin
                    state_d = ST_FETCH;
                end
            end

            ST_TRAP: begin
                state_d = ST_TRAP;
            end

            default: begin
                state_d = ST_TRAP;
            end
        endcase
    end

    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign instret    = instret_q;
    assign state      = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;

    localparam int TO = 4;
    localparam int CW = 4;   // narrow counter so wrap-around is exercised

    // spec state numbering
    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
                           MEM = 3'd4, WB = 3'd5, HALT = 3'd6, TRAP = 3'd7;

    // decoder flag bits: rd, alu, mem, rw, jal, jalr, branch, fence, system, invalid
    localparam logic [9:0] F_RD = 10'h200, F_ALU = 10'h100, F_MEM = 10'h080,
                           F_RW = 10'h040, F_JAL = 10'h020, F_JALR = 10'h010,
                           F_BR = 10'h008, F_FENCE = 10'h004, F_SYS = 10'h002,
                           F_INV = 10'h001;

    // strobe bits: if_req, ir_load, alu_go, mem_req, mem_we, reg_we, pc_load, pc_sel
    localparam logic [7:0] O_IFR = 8'h80, O_IRL = 8'h40, O_ALU = 8'h20, O_MREQ = 8'h10,
                           O_MWE = 8'h08, O_RWE = 8'h04, O_PCL = 8'h02, O_PCS = 8'h01;

    typedef struct packed {
        logic       halt;
        logic       ia;
        logic       ma;
        logic       bt;
        logic [9:0] f;
    } in_t;

    typedef struct packed {
        logic [2:0]    st;
        logic [7:0]    s;
        logic          trap;
        logic [1:0]    cause;
        logic [CW-1:0] cnt;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic halt_req = 1'b0, if_ack = 1'b0, mem_ack = 1'b0, br_taken = 1'b0;
    logic dec_rd_enc = 1'b0, dec_alu_en = 1'b0, dec_mem_en = 1'b0, dec_rw = 1'b0;
    logic dec_is_jal = 1'b0, dec_is_jalr = 1'b0, dec_is_branch = 1'b0;
    logic dec_is_fence = 1'b0, dec_is_system = 1'b0, dec_is_invalid = 1'b0;
    logic if_req, ir_load, alu_go, mem_req, mem_we, reg_we, pc_load, pc_sel, trap;
    logic [1:0]    trap_cause;
    logic [CW-1:0] instret;
    logic [2:0]    state;

    core_sequencer #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .nreset(nreset), .halt_req(halt_req),
        .if_req(if_req), .if_ack(if_ack), .ir_load(ir_load),
        .dec_rd_enc(dec_rd_enc), .dec_alu_en(dec_alu_en), .dec_mem_en(dec_mem_en),
        .dec_rw(dec_rw), .dec_is_jal(dec_is_jal), .dec_is_jalr(dec_is_jalr),
        .dec_is_branch(dec_is_branch), .dec_is_fence(dec_is_fence),
        .dec_is_system(dec_is_system), .dec_is_invalid(dec_is_invalid),
        .br_taken(br_taken), .alu_go(alu_go), .mem_req(mem_req), .mem_we(mem_we),
        .mem_ack(mem_ack), .reg_we(reg_we), .pc_load(pc_load), .pc_sel(pc_sel),
        .trap(trap), .trap_cause(trap_cause), .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    out_t act;
    assign act = {state, if_req, ir_load, alu_go, mem_req, mem_we, reg_we, pc_load,
                  pc_sel, trap, trap_cause, instret};

    int nvec = 0;
    int nerr = 0;

    // reference model state
    logic [CW-1:0] m_cnt = '0;
    bit            m_trap = 1'b0;

    function automatic bit rb();
        return ($urandom & 32'd1) != 0;
    endfunction

    function automatic in_t mi(bit h, bit ia, bit ma, bit bt, logic [9:0] f);
        return {h, ia, ma, bt, f};
    endfunction

    function automatic out_t mo(logic [2:0] st, logic [7:0] s, logic tr, logic [1:0] c,
                                logic [CW-1:0] n);
        return {st, s, tr, c, n};
    endfunction

    // expectation while running normally (no trap yet)
    function automatic out_t ok(logic [2:0] st, logic [7:0] s);
        return {st, s, 1'b0, 2'b00, m_cnt};
    endfunction

    task automatic drive(input in_t i);
        halt_req = i.halt;
        if_ack   = i.ia;
        mem_ack  = i.ma;
        br_taken = i.bt;
        {dec_rd_enc, dec_alu_en, dec_mem_en, dec_rw, dec_is_jal, dec_is_jalr,
         dec_is_branch, dec_is_fence, dec_is_system, dec_is_invalid} = i.f;
    endtask

    task automatic chk(input out_t e, input string nm);
        nvec++;
        if (act !== e) begin
            nerr++;
            $display("FAIL %s @%0t: got st=%0d strobes=%b trap=%b cause=%b instret=%0d, want st=%0d strobes=%b trap=%b cause=%b instret=%0d",
                     nm, $time, act.st, act.s, act.trap, act.cause, act.cnt,
                     e.st, e.s, e.trap, e.cause, e.cnt);
        end
    endtask

    // called just after a rising edge; checks on the falling edge
    task automatic run_cyc(input in_t i, input out_t e, input string nm);
        drive(i);
        @(negedge clk);
        chk(e, nm);
        @(posedge clk);
        #1;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        nreset = 1'b1;
        m_cnt  = '0;
        m_trap = 1'b0;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        drive(mi(rb(), rb(), rb(), rb(), 10'($urandom)));
        @(negedge clk);
        chk(mo(IDLE, 8'h00, 1'b0, 2'b00, '0), "reset_state");
        release_rst();
    endtask

    // HALT residency: hl cycles with the request still high, then release
    task automatic halt_hold(input int hl);
        for (int k = 0; k < hl; k++)
            run_cyc(mi(1, rb(), rb(), rb(), 10'($urandom)), ok(HALT, 8'h00), "halt_held");
        run_cyc(mi(0, rb(), rb(), rb(), 10'($urandom)), ok(HALT, 8'h00), "halt_release");
    endtask

    // single IDLE cycle after reset; hl >= 0 requests a halt there
    task automatic idle_cycle(input int hl);
        run_cyc(mi(hl >= 0, rb(), rb(), rb(), 10'($urandom)), ok(IDLE, 8'h00), "idle");
        if (hl >= 0) halt_hold(hl);
    endtask

    task automatic trap_hold(input logic [1:0] c);
        for (int k = 0; k < 22; k++)
            run_cyc(mi(rb(), rb(), rb(), rb(), 10'($urandom)),
                    mo(TRAP, 8'h00, 1'b1, c, m_cnt), "trap_sticky");
        m_trap = 1'b1;
    endtask

    // One instruction from FETCH entry. fw/mw: number of wait cycles before
    // the ack (>= TO means no ack at all). hl >= 0 raises halt from EXEC on
    // and holds it hl cycles in HALT.
    task automatic run_instr(input logic [9:0] f, input int fw, input int mw,
                             input bit taken, input int hl);
        int  nf, nm;
        bit  ack, hb, sel;
        hb = (hl >= 0);
        nf = (fw < TO) ? fw + 1 : TO;
        for (int k = 0; k < nf; k++) begin
            ack = (fw < TO) && (k == fw);
            run_cyc(mi(rb(), ack, rb(), rb(), f),
                    ok(FETCH, O_IFR | (ack ? O_IRL : 8'h00)), "fetch");
        end
        if (fw >= TO) begin trap_hold(2'b10); return; end
        run_cyc(mi(rb(), rb(), rb(), rb(), f), ok(DECODE, 8'h00), "decode");
        if (f[0]) begin trap_hold(2'b01); return; end
        run_cyc(mi(hb | rb(), rb(), rb(), taken, f),
                ok(EXEC, f[8] ? O_ALU : 8'h00), "exec");
        if (f[7]) begin
            nm = (mw < TO) ? mw + 1 : TO;
            for (int k = 0; k < nm; k++) begin
                ack = (mw < TO) && (k == mw);
                run_cyc(mi(hb | rb(), rb(), ack, rb(), f),
                        ok(MEM, O_MREQ | (f[6] ? 8'h00 : O_MWE)), "mem");
            end
            if (mw >= TO) begin trap_hold(2'b11); return; end
        end
        sel = f[5] | f[4] | (f[3] & taken);
        run_cyc(mi(hb, rb(), rb(), rb(), f),
                ok(WB, (f[9] ? O_RWE : 8'h00) | O_PCL | (sel ? O_PCS : 8'h00)), "wb");
        m_cnt = m_cnt + 1'b1;
        if (hb) halt_hold(hl);
    endtask

    function automatic logic [9:0] rand_instr();
        case ($urandom % 8)
            0: return F_RD | F_ALU;
            1: return F_RD | F_ALU | F_MEM | F_RW;
            2: return F_ALU | F_MEM;
            3: return F_ALU | F_BR;
            4: return F_RD | F_JAL;
            5: return F_RD | F_ALU | F_JALR;
            6: return F_FENCE;
            default: return F_SYS | (rb() ? F_RD : 10'h000);
        endcase
    endfunction

    localparam logic [9:0] A = F_RD | F_ALU;
    localparam logic [9:0] L = F_RD | F_ALU | F_MEM | F_RW;

    vec_t tbl[12];

    initial begin
        // ALU op with same-cycle fetch ack, then a load acked on its 3rd MEM cycle
        tbl[0]  = '{mi(0,0,0,0,A), mo(IDLE,   8'h00,         0, 2'b00, 4'd0)};
        tbl[1]  = '{mi(0,1,0,0,A), mo(FETCH,  O_IFR | O_IRL, 0, 2'b00, 4'd0)};
        tbl[2]  = '{mi(0,0,0,0,A), mo(DECODE, 8'h00,         0, 2'b00, 4'd0)};
        tbl[3]  = '{mi(0,0,0,0,A), mo(EXEC,   O_ALU,         0, 2'b00, 4'd0)};
        tbl[4]  = '{mi(0,0,0,0,A), mo(WB,     O_RWE | O_PCL, 0, 2'b00, 4'd0)};
        tbl[5]  = '{mi(0,1,0,0,L), mo(FETCH,  O_IFR | O_IRL, 0, 2'b00, 4'd1)};
        tbl[6]  = '{mi(0,0,0,0,L), mo(DECODE, 8'h00,         0, 2'b00, 4'd1)};
        tbl[7]  = '{mi(0,0,0,0,L), mo(EXEC,   O_ALU,         0, 2'b00, 4'd1)};
        tbl[8]  = '{mi(0,0,0,0,L), mo(MEM,    O_MREQ,        0, 2'b00, 4'd1)};
        tbl[9]  = '{mi(0,0,0,0,L), mo(MEM,    O_MREQ,        0, 2'b00, 4'd1)};
        tbl[10] = '{mi(0,0,1,0,L), mo(MEM,    O_MREQ,        0, 2'b00, 4'd1)};
        tbl[11] = '{mi(0,0,0,0,L), mo(WB,     O_RWE | O_PCL, 0, 2'b00, 4'd1)};

        #2;
        do_reset();
        for (int k = 0; k < 12; k++)
            run_cyc(tbl[k].i, tbl[k].o, $sformatf("tbl%0d", k));
        m_cnt = 4'd2;

        // control-flow and miscellaneous classes
        run_instr(F_ALU | F_BR,         0, 0, 1, -1);  // branch taken
        run_instr(F_ALU | F_BR,         0, 0, 0, -1);  // branch not taken
        run_instr(F_RD | F_JAL,         0, 0, 0, -1);
        run_instr(F_RD | F_ALU | F_JALR, 1, 0, 0, -1);
        run_instr(F_FENCE,              0, 0, 1, -1);
        run_instr(F_SYS | F_RD,         2, 0, 0, -1);
        run_instr(F_ALU | F_MEM,        0, TO - 1, 0, -1);  // store, ack on last cycle
        run_instr(A,                    TO - 1, 0, 0, -1);  // fetch ack on last cycle
        run_instr(A,                    0, 0, 0, 3);        // halt from EXEC, held 3
        run_instr(L,                    0, 1, 0, 0);        // halt released at once
        run_instr(F_ALU | F_MEM,        0, TO, 0, -1);      // store timeout -> cause 11

        // invalid opcode after a retire
        do_reset();
        idle_cycle(-1);
        run_instr(A, 0, 0, 0, -1);
        run_instr(F_INV | F_RD, 0, 0, 0, -1);

        // fetch timeout, and halt requested in IDLE
        do_reset();
        idle_cycle(2);
        run_instr(A, 0, 0, 0, -1);
        run_instr(A, TO, 0, 0, -1);

        // reset in the middle of a fetch
        do_reset();
        idle_cycle(-1);
        drive(mi(0, 0, 0, 0, A));
        #1;
        chk(ok(FETCH, O_IFR), "fetch_before_rst");
        nreset = 1'b0;
        #1;
        chk(mo(IDLE, 8'h00, 1'b0, 2'b00, '0), "rst_mid_fetch");
        release_rst();

        // reset in the middle of a load: no write-back, instret cleared
        idle_cycle(-1);
        run_instr(A, 0, 0, 0, -1);
        run_cyc(mi(0, 1, 0, 0, L), ok(FETCH, O_IFR | O_IRL), "rm_fetch");
        run_cyc(mi(0, 0, 0, 0, L), ok(DECODE, 8'h00), "rm_decode");
        run_cyc(mi(0, 0, 0, 0, L), ok(EXEC, O_ALU), "rm_exec");
        run_cyc(mi(0, 0, 0, 0, L), ok(MEM, O_MREQ), "rm_mem");
        #1;
        chk(ok(MEM, O_MREQ), "mem_before_rst");
        nreset = 1'b0;
        #1;
        chk(mo(IDLE, 8'h00, 1'b0, 2'b00, '0), "rst_mid_mem");
        release_rst();
        idle_cycle(-1);
        run_instr(A, 0, 0, 0, -1);

        // counter wrap
        for (int k = 0; k < 18; k++) run_instr(A, 0, 0, 0, -1);
        do_reset();

        // randomized runs against the model
        for (int r = 0; r < 6; r++) begin
            do_reset();
            idle_cycle((($urandom % 4) == 0) ? int'($urandom % 3) : -1);
            for (int n = 0; n < 25 && !m_trap; n++) begin
                logic [9:0] f;
                int fw, mw, hl;
                f  = (($urandom % 30) == 0) ? (F_INV | rand_instr()) : rand_instr();
                fw = (($urandom % 20) == 0) ? TO : int'($urandom % TO);
                mw = (($urandom % 20) == 0) ? TO : int'($urandom % TO);
                hl = (($urandom % 5) == 0) ? int'($urandom % 3) : -1;
                run_instr(f, fw, mw, rb(), hl);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
